// File: rtl/id_ex_stage.sv
// id_ex_stage
//   Pipeline register between decode and execute. It holds one instruction,
//   stalls on load-use hazards by inserting a single bubble, honours
//   backpressure from execute, and can be squashed by flush.
//
// Handshake: a transfer from decode happens on a rising edge where
// id_valid && id_ready. The stage presents an instruction to execute while
// ex_valid; it leaves on an edge where ex_valid && ex_ready. While
// ex_valid && !ex_ready, every ex_* output holds steady.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   flush                         squash the held instruction / the decode slot
//   id_valid / id_ready           decode-side handshake
//   id_pc, id_imm                 instruction PC, extended immediate
//   id_rs_addr/id_rt_addr         source register numbers
//   id_rs_used/id_rt_used         instruction actually reads rs / rt
//   id_rs_value/id_rt_value       operand values from the decode bypass
//   id_alu_op                     ALU operation (ALU_OP_W bits)
//   id_dst_en/id_dst_addr         writeback enable / destination
//   id_is_load                    instruction is a load
//   ex_valid / ex_ready           execute-side handshake
//   ex_*                          registered copies of the id_* fields
//   bubble_count                  saturating count of load-use bubbles
module id_ex_stage #(
    parameter int ALU_OP_W = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [31:0]         id_pc,
    input  logic [31:0]         id_imm,
    input  logic [4:0]          id_rs_addr,
    input  logic [4:0]          id_rt_addr,
    input  logic                id_rs_used,
    input  logic                id_rt_used,
    input  logic [31:0]         id_rs_value,
    input  logic [31:0]         id_rt_value,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic                id_dst_en,
    input  logic [4:0]          id_dst_addr,
    input  logic                id_is_load,
    input  logic                ex_ready,
    output logic                ex_valid,
    output logic [31:0]         ex_pc,
    output logic [31:0]         ex_imm,
    output logic [31:0]         ex_rs_value,
    output logic [31:0]         ex_rt_value,
    output logic [ALU_OP_W-1:0] ex_alu_op,
    output logic                ex_dst_en,
    output logic [4:0]          ex_dst_addr,
    output logic                ex_is_load,
    output logic [31:0]         bubble_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                load_en;
    logic                bubble_inc;
    logic                advance;
    logic                hazard;

    logic [31:0]         pc_q, imm_q, rs_value_q, rt_value_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic                dst_en_q, is_load_q;
    logic [4:0]          dst_addr_q;
    logic [31:0]         bubble_count_q;

    assign ex_valid = (state_q == FULL);

    // The slot frees up this cycle if it is empty or its occupant is leaving.
    assign advance = !ex_valid || ex_ready;

    // A load in execute has not produced its data yet; a consumer in decode
    // must wait one cycle so the memory-stage bypass can supply it.
    // Register 0 is hardwired and never creates a dependency.
    assign hazard = ex_valid && is_load_q && dst_en_q && (dst_addr_q != 5'd0) &&
                    ((id_rs_used && (id_rs_addr == dst_addr_q)) ||
                     (id_rt_used && (id_rt_addr == dst_addr_q)));

    assign id_ready = advance && !hazard && !flush;

    always_comb begin
        state_d    = state_q;
        load_en    = 1'b0;
        bubble_inc = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else if (advance && id_valid && !hazard) begin
            state_d = FULL;
            load_en = 1'b1;
        end else if (advance) begin
            // Nothing accepted (or hazard): the slot drains to a bubble.
            state_d    = EMPTY;
            bubble_inc = id_valid && hazard;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload only changes on an accepted transfer; flush and bubbles leave
    // it untouched since ex_valid already marks it as dead.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= '0;
            imm_q      <= '0;
            rs_value_q <= '0;
            rt_value_q <= '0;
            alu_op_q   <= '0;
            dst_en_q   <= 1'b0;
            dst_addr_q <= '0;
            is_load_q  <= 1'b0;
        end else if (load_en) begin
            pc_q       <= id_pc;
            imm_q      <= id_imm;
            rs_value_q <= id_rs_value;
            rt_value_q <= id_rt_value;
            alu_op_q   <= id_alu_op;
            dst_en_q   <= id_dst_en;
            dst_addr_q <= id_dst_addr;
            is_load_q  <= id_is_load;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_count_q <= '0;
        end else if (bubble_inc && (bubble_count_q != 32'hFFFF_FFFF)) begin
            bubble_count_q <= bubble_count_q + 32'd1;
        end
    end

    assign ex_pc        = pc_q;
    assign ex_imm       = imm_q;
    assign ex_rs_value  = rs_value_q;
    assign ex_rt_value  = rt_value_q;
    assign ex_alu_op    = alu_op_q;
    assign ex_dst_en    = dst_en_q;
    assign ex_dst_addr  = dst_addr_q;
    assign ex_is_load   = is_load_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc, id_imm;
    logic [4:0]  id_rs_addr, id_rt_addr;
    logic        id_rs_used, id_rt_used;
    logic [31:0] id_rs_value, id_rt_value;
    logic [5:0]  id_alu_op;
    logic        id_dst_en;
    logic [4:0]  id_dst_addr;
    logic        id_is_load;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_imm, ex_rs_value, ex_rt_value;
    logic [5:0]  ex_alu_op;
    logic        ex_dst_en;
    logic [4:0]  ex_dst_addr;
    logic        ex_is_load;
    logic [31:0] bubble_count;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.ALU_OP_W(6)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_imm(id_imm),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_rs_value(id_rs_value), .id_rt_value(id_rt_value),
        .id_alu_op(id_alu_op), .id_dst_en(id_dst_en),
        .id_dst_addr(id_dst_addr), .id_is_load(id_is_load),
        .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs_value(ex_rs_value), .ex_rt_value(ex_rt_value),
        .ex_alu_op(ex_alu_op), .ex_dst_en(ex_dst_en),
        .ex_dst_addr(ex_dst_addr), .ex_is_load(ex_is_load),
        .bubble_count(bubble_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_instr(input logic [31:0] pc, input logic is_load, input logic [4:0] dst,
                               input logic [4:0] rs, input logic rs_used,
                               input logic [4:0] rt, input logic rt_used);
        id_valid    = 1'b1;
        id_pc       = pc;
        id_imm      = pc ^ 32'h0000_FFFF;
        id_rs_value = pc + 32'h1000;
        id_rt_value = pc + 32'h2000;
        id_alu_op   = pc[7:2];
        id_dst_en   = 1'b1;
        id_dst_addr = dst;
        id_is_load  = is_load;
        id_rs_addr  = rs;
        id_rs_used  = rs_used;
        id_rt_addr  = rt;
        id_rt_used  = rt_used;
        #1;
    endtask

    initial begin
        // Reset and idle inputs
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
        id_pc = '0; id_imm = '0; id_rs_addr = '0; id_rt_addr = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0; id_rs_value = '0; id_rt_value = '0;
        id_alu_op = '0; id_dst_en = 1'b0; id_dst_addr = '0; id_is_load = 1'b0;
        #2;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_ex_pc", ex_pc, 32'd0);
        check("rst_bubbles", bubble_count, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("idle_id_ready", 32'(id_ready), 32'd1);

        // Back-to-back stream, no hazards
        drive_instr(32'h100, 1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        check("stream_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("stream0_valid", 32'(ex_valid), 32'd1);
        check("stream0_pc", ex_pc, 32'h100);
        check("stream0_imm", ex_imm, 32'h0000_FEFF);
        check("stream0_rs", ex_rs_value, 32'h1100);
        check("stream0_rt", ex_rt_value, 32'h2100);
        check("stream0_alu", 32'(ex_alu_op), 32'h00);
        check("stream0_dst", 32'(ex_dst_addr), 32'd1);
        check("stream0_dst_en", 32'(ex_dst_en), 32'd1);
        check("stream0_load", 32'(ex_is_load), 32'd0);
        drive_instr(32'h104, 1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        tick();
        check("stream1_valid", 32'(ex_valid), 32'd1);
        check("stream1_pc", ex_pc, 32'h104);
        check("stream1_alu", 32'(ex_alu_op), 32'h01);
        drive_instr(32'h108, 1'b0, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        tick();
        check("stream2_valid", 32'(ex_valid), 32'd1);
        check("stream2_pc", ex_pc, 32'h108);
        check("stream_bubbles", bubble_count, 32'd0);

        // Load-use on rs: one bubble, then accept
        drive_instr(32'h300, 1'b1, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        check("lu_load_in_ex", 32'(ex_is_load), 32'd1);
        drive_instr(32'h304, 1'b0, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
        check("lu_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("lu_bubble_valid", 32'(ex_valid), 32'd0);
        check("lu_bubbles", bubble_count, 32'd1);
        check("lu_ready_after", 32'(id_ready), 32'd1);
        tick();
        check("lu_accept_valid", 32'(ex_valid), 32'd1);
        check("lu_accept_pc", ex_pc, 32'h304);
        check("lu_bubbles_held", bubble_count, 32'd1);

        // Load writing r0 never hazards
        drive_instr(32'h400, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive_instr(32'h404, 1'b1, 5'd7, 5'd0, 1'b1, 5'd0, 1'b1);
        check("r0_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("r0_pc", ex_pc, 32'h404);
        check("r0_valid", 32'(ex_valid), 32'd1);
        // Matching rs address but rs unused: no hazard
        drive_instr(32'h408, 1'b1, 5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        check("unused_id_ready", 32'(id_ready), 32'd1);
        tick();
        check("unused_pc", ex_pc, 32'h408);
        check("unused_bubbles", bubble_count, 32'd1);
        // Hazard through rt
        drive_instr(32'h40C, 1'b0, 5'd8, 5'd1, 1'b1, 5'd7, 1'b1);
        check("rt_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("rt_bubble_valid", 32'(ex_valid), 32'd0);
        check("rt_bubbles", bubble_count, 32'd2);
        tick();
        check("rt_accept_pc", ex_pc, 32'h40C);
        check("rt_accept_valid", 32'(ex_valid), 32'd1);

        // Backpressure from execute
        drive_instr(32'h200, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        check("bp_pc0", ex_pc, 32'h200);
        ex_ready = 1'b0;
        drive_instr(32'h204, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        check("bp_id_ready", 32'(id_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_hold_pc", ex_pc, 32'h200);
            check("bp_hold_valid", 32'(ex_valid), 32'd1);
            check("bp_hold_ready", 32'(id_ready), 32'd0);
        end
        ex_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(id_ready), 32'd1);
        tick();
        check("bp_accept_pc", ex_pc, 32'h204);

        // Flush beats hazard and accept
        drive_instr(32'h500, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        drive_instr(32'h504, 1'b0, 5'd2, 5'd9, 1'b1, 5'd0, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_id_ready", 32'(id_ready), 32'd0);
        tick();
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_bubbles", bubble_count, 32'd2);
        check("fl_payload_held", ex_pc, 32'h500);
        flush = 1'b0;
        #1;
        tick();
        check("fl_after_pc", ex_pc, 32'h504);
        check("fl_after_valid", 32'(ex_valid), 32'd1);

        // Asynchronous reset between edges while FULL
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid", 32'(ex_valid), 32'd0);
        check("ar_pc", ex_pc, 32'd0);
        check("ar_imm", ex_imm, 32'd0);
        check("ar_rs", ex_rs_value, 32'd0);
        check("ar_rt", ex_rt_value, 32'd0);
        check("ar_alu", 32'(ex_alu_op), 32'd0);
        check("ar_dst", 32'(ex_dst_addr), 32'd0);
        check("ar_dst_en", 32'(ex_dst_en), 32'd0);
        check("ar_load", 32'(ex_is_load), 32'd0);
        check("ar_bubbles", bubble_count, 32'd0);
        id_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_idle", 32'(ex_valid), 32'd0);
        drive_instr(32'h600, 1'b0, 5'd1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        check("post_rst_valid", 32'(ex_valid), 32'd1);
        check("post_rst_pc", ex_pc, 32'h600);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bound the run regardless of what the sequence above does.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
